// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, FSM states and timer width helper for the code lock
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPEN,
      LOCKOUT
   } state_t;

   function automatic int timer_w(input int open_cycles, input int lock_cycles);
      return $clog2(((open_cycles > lock_cycles) ? open_cycles : lock_cycles) + 1);
   endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter shared by the OPEN and LOCKOUT hold periods
module hold_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;
   logic         running;

   // expired is asserted during the cycle the count sits at zero, so a load of N-1 holds N cycles
   assign expired = running && (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         running <= 1'b0;
      end else if (abort) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         count   <= load_val;
         running <= 1'b1;
      end else if (running) begin
         if (count == '0)
            running <= 1'b0;
         else
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/keypad_code_lock.sv
// rtl/keypad_code_lock.sv - assembles keypad digits, checks the entry and drives unlock/fail/locked
import keypad_pkg::*;

module keypad_code_lock #(
   parameter int                    CODE_LEN    = 4,
   parameter logic [4*CODE_LEN-1:0] PASSWORD    = 16'h1379,
   parameter int                    MAX_FAIL    = 3,
   parameter int                    OPEN_CYCLES = 500,
   parameter int                    LOCK_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            key_code,
   input  logic                  key_valid,
   output logic [4*CODE_LEN-1:0] entry_digits,
   output logic [3:0]            entry_count,
   output logic                  unlock,
   output logic                  fail,
   output logic                  locked
);

   localparam int TW = timer_w(OPEN_CYCLES, LOCK_CYCLES);
   localparam int FW = $clog2(MAX_FAIL + 1);

   state_t                state;
   logic                  hash_q;
   logic [FW-1:0]         fail_cnt;
   logic [FW-1:0]         next_fail;
   logic [4*CODE_LEN+3:0] shifted;
   logic                  match;
   logic                  to_lockout;
   logic                  star_key;
   logic                  tmr_start;
   logic                  tmr_abort;
   logic                  tmr_expired;
   logic [TW-1:0]         tmr_load;

   always_comb begin
      shifted    = {entry_digits, key_code};
      match      = (entry_count == 4'(CODE_LEN)) && (entry_digits == PASSWORD);
      next_fail  = fail_cnt + FW'(1);
      to_lockout = !match && (next_fail == FW'(MAX_FAIL));
      star_key   = key_valid && (key_code == KEY_STAR);
      tmr_start  = (state == CHECK) && (match || to_lockout);
      tmr_load   = match ? TW'(OPEN_CYCLES - 1) : TW'(LOCK_CYCLES - 1);
      tmr_abort  = (state == OPEN) && star_key;
   end

   hold_timer #(.W(TW)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (tmr_start),
      .abort    (tmr_abort),
      .load_val (tmr_load),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         hash_q       <= 1'b0;
         fail_cnt     <= '0;
         entry_digits <= '0;
         entry_count  <= '0;
         unlock       <= 1'b0;
         fail         <= 1'b0;
         locked       <= 1'b0;
      end else begin
         fail <= 1'b0;
         case (state)
            IDLE, ENTRY: begin
               // '#' waits one cycle in hash_q before CHECK; keys in that cycle are dropped
               if (hash_q) begin
                  hash_q <= 1'b0;
                  state  <= CHECK;
               end else if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (entry_count < 4'(CODE_LEN)) begin
                        entry_digits <= shifted[4*CODE_LEN-1:0];
                        entry_count  <= entry_count + 4'd1;
                        state        <= ENTRY;
                     end
                  end else if (key_code == KEY_STAR) begin
                     entry_digits <= '0;
                     entry_count  <= '0;
                     state        <= IDLE;
                  end else if (key_code == KEY_HASH) begin
                     hash_q <= 1'b1;
                  end
               end
            end
            CHECK: begin
               entry_digits <= '0;
               entry_count  <= '0;
               if (match) begin
                  state    <= OPEN;
                  unlock   <= 1'b1;
                  fail_cnt <= '0;
               end else begin
                  fail     <= 1'b1;
                  fail_cnt <= next_fail;
                  if (to_lockout) begin
                     state  <= LOCKOUT;
                     locked <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OPEN: begin
               if (tmr_expired || star_key) begin
                  unlock <= 1'b0;
                  state  <= IDLE;
               end
            end
            LOCKOUT: begin
               if (tmr_expired) begin
                  locked   <= 1'b0;
                  fail_cnt <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/keypad_code_lock.md
# keypad_code_lock

Consumer end of the keypad scanner interface: takes the 4-bit key code stream with its one-cycle valid strobe and assembles digits into a fixed-length entry. It checks the entry against a parameterised password on the enter key and drives unlock, fail and lockout indications. It sits directly downstream of the keypad scanner and upstream of the door/LED/7-segment output logic.

## Interface
- CODE_LEN, 4: number of digits in a complete entry (1..8)
- PASSWORD, 16'h1379: expected entry, BCD, 4 bits per digit, first-entered digit in the most significant nibble; width 4*CODE_LEN
- MAX_FAIL, 3: consecutive failed checks that trigger lockout (≥1)
- OPEN_CYCLES, 500: cycles unlock stays high
- LOCK_CYCLES, 1000: cycles locked stays high
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- key_code  input  4  key code: 0-9 digits, 10 = '*' (clear), 11 = '#' (enter), 12-15 reserved
- key_valid  input  1  one-cycle strobe; key_code is valid in the same cycle
- entry_digits  output  4*CODE_LEN  BCD entry buffer for display, newest digit in the least significant nibble
- entry_count  output  4  digits currently held (0..CODE_LEN)
- unlock  output  1  high for OPEN_CYCLES after a correct check
- fail  output  1  one-cycle pulse per failed check
- locked  output  1  high for LOCK_CYCLES after MAX_FAIL consecutive failures

## Operation
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, failure counter 0, timer 0.
- States: IDLE (count=0), ENTRY (count>0), CHECK, OPEN, LOCKOUT.
- IDLE/ENTRY, key_valid=1:
  - digit 0-9 with count<CODE_LEN: shift into entry_digits from the LSB; count+1; state ENTRY.
  - digit with count=CODE_LEN: ignored.
  - '*': buffer and count cleared; state IDLE.
  - '#': state CHECK, even when count=0.
  - codes 12-15: ignored.
- CHECK lasts one cycle. Match is count=CODE_LEN and entry_digits=PASSWORD.
  - Match: state OPEN, unlock=1, failure counter cleared.
  - No match: fail pulse; failure counter +1. If the counter reaches MAX_FAIL, state LOCKOUT, locked=1. Otherwise state IDLE.
  - Buffer and count are cleared on exit from CHECK in every case.
- OPEN: timer loads OPEN_CYCLES-1 and counts down. On expiry, unlock=0 and state IDLE. A '*' key ends OPEN early, effective the next cycle. All other keys are ignored.
- LOCKOUT: timer loads LOCK_CYCLES-1. Every key is ignored. On expiry, locked=0, failure counter cleared, state IDLE.
- key_valid high on consecutive cycles counts as separate keys. The block does no debouncing.
- No arithmetic overflow is possible: count saturates at CODE_LEN and the failure counter saturates at MAX_FAIL.

## Timing
- All outputs are registered.
- Key sampled at edge t: entry_digits and entry_count are updated after edge t.
- '#' sampled at edge t: CHECK during cycle t+1; unlock or fail is high after edge t+2. The buffer reads 0 from the same edge.
- unlock is high for exactly OPEN_CYCLES cycles. locked is high for exactly LOCK_CYCLES cycles. fail is high for exactly 1 cycle.
- The first key after OPEN or LOCKOUT is accepted in the cycle after unlock or locked falls.
- A key arriving in the same cycle the block is in CHECK is dropped.
- Reset mid-operation takes effect immediately on every output, including mid-OPEN and mid-LOCKOUT. No pending event survives reset.

## Structure
- Package keypad_pkg holds:
  - key code constants KEY_STAR=4'd10 and KEY_HASH=4'd11
  - the state enum {IDLE, ENTRY, CHECK, OPEN, LOCKOUT}
  - width helper for the timer, $clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1)
- Sub-module hold_timer: loadable down-counter with load value, start and expired pulse. It is shared by OPEN and LOCKOUT.
- The FSM, entry shift register and failure counter stay in keypad_code_lock.

## Test plan
- Keys 1,3,7,9,'#' with default parameters: unlock high at '#'+2 for exactly 500 cycles; fail=0; entry_count returns to 0.
- Keys 1,3,7,8,'#': one fail pulse at '#'+2; unlock stays 0; state returns to IDLE.
- Three wrong entries in a row: fail pulses three times; locked rises with the third fail and stays high for 1000 cycles. Keys sent during lockout change nothing. Then 1,3,7,9,'#' unlocks.
- Keys 1,3,'*',1,3,7,9,9,'#': the '*' clears the buffer and the fifth digit is ignored. entry_digits reads 16'h1379 before '#', then unlock follows.
- '#' with count=0, and key code 12 during entry: '#' gives a fail pulse; code 12 leaves entry_count unchanged.
- rst pulled low during OPEN and during LOCKOUT: unlock, locked, entry_count and entry_digits are 0 immediately. The failure counter is cleared, so one wrong entry after release does not lock.
